// File: rtl/mulen_pkg.sv
// Shared arithmetic for the mulen Booth multiplier: pair decode, one Booth step, round/saturate.
// Values travel through these helpers sign-extended to WIDE_W bits, so any legal AW/BW/PW/FRAC fits.
package mulen_pkg;

  localparam int WIDE_W = 128;

  typedef logic signed [WIDE_W-1:0] wide_t;

  typedef enum logic [1:0] {
    OP_NONE,
    OP_ADD,
    OP_SUB
  } booth_op_e;

  typedef struct packed {
    wide_t value;
    logic  sat;
  } rs_t;

  // Radix-2 Booth recoding of the bit pair (b[k], b[k-1]).
  function automatic booth_op_e booth_decode(input logic [1:0] pair);
    booth_op_e op;
    case (pair)
      2'b01:   op = OP_ADD;
      2'b10:   op = OP_SUB;
      default: op = OP_NONE;
    endcase
    return op;
  endfunction

  function automatic wide_t booth_step(input wide_t acc, input wide_t a_sh, input logic [1:0] pair);
    wide_t res;
    case (booth_decode(pair))
      OP_ADD:  res = acc + a_sh;
      OP_SUB:  res = acc - a_sh;
      default: res = acc;
    endcase
    return res;
  endfunction

  // Round half up, arithmetic shift by frac (floor), then clip to a pw-bit signed range.
  function automatic rs_t round_sat(input wide_t acc, input int frac, input int pw);
    rs_t   res;
    wide_t r;
    wide_t max_v;
    wide_t min_v;
    r = acc;
    if (frac > 0) r = r + (wide_t'(1) <<< (frac - 1));
    r     = r >>> frac;
    max_v = (wide_t'(1) <<< (pw - 1)) - wide_t'(1);
    min_v = -(wide_t'(1) <<< (pw - 1));
    res.sat = 1'b0;
    if (r > max_v) begin
      res.value = max_v;
      res.sat   = 1'b1;
    end else if (r < min_v) begin
      res.value = min_v;
      res.sat   = 1'b1;
    end else begin
      res.value = r;
    end
    return res;
  endfunction

endpackage

// File: rtl/mulen_stage.sv
// One Booth step of the mulen pipeline: scans multiplier bits (b[K], b[K-1]) and carries
// the operands and accumulator forward; data registers only load behind a valid token.
module mulen_stage
  import mulen_pkg::*;
#(
  parameter int AW = 26,
  parameter int BW = 26,
  parameter int K  = 0
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   cke,
  input  logic                   v_in,
  input  logic signed [AW-1:0]   a_in,
  input  logic signed [BW-1:0]   b_in,
  input  logic signed [AW+BW-1:0] acc_in,
  output logic                   v_out,
  output logic signed [AW-1:0]   a_out,
  output logic signed [BW-1:0]   b_out,
  output logic signed [AW+BW-1:0] acc_out
);

  localparam int ACCW = AW + BW;

  logic             b_lo;
  wide_t            sum;
  logic [ACCW-1:0]  acc_d;

  if (K == 0) begin : g_first
    assign b_lo = 1'b0;
  end else begin : g_rest
    assign b_lo = b_in[K-1];
  end

  // NOTE: every variable driven here gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    sum   = '0;
    acc_d = '0;
    sum   = booth_step(wide_t'(acc_in), wide_t'(a_in) <<< K, {b_in[K], b_lo});
    acc_d = sum[ACCW-1:0];
  end

  // NOTE: state uses non-blocking assignments so every stage samples pre-edge values of its neighbour.
  // The data registers are few and explicitly cleared, so they share the async reset with the valid bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v_out   <= 1'b0;
      a_out   <= '0;
      b_out   <= '0;
      acc_out <= '0;
    end else if (cke) begin
      v_out <= v_in;
      if (v_in) begin
        a_out   <= a_in;
        b_out   <= b_in;
        acc_out <= acc_d;
      end
    end
  end

endmodule

// File: rtl/mulen.sv
// Fully pipelined radix-2 Booth multiplier with round, shift and saturate.
// BW Booth stages plus one output stage give a latency of BW+1 cke-enabled edges.
module mulen
  import mulen_pkg::*;
#(
  parameter int AW   = 26,
  parameter int BW   = 26,
  parameter int PW   = 26,
  parameter int FRAC = 24
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 cke,
  input  logic                 vin,
  input  logic signed [AW-1:0] multiplicand,
  input  logic signed [BW-1:0] multiplier,
  output logic signed [PW-1:0] product,
  output logic                 sat,
  output logic                 vout
);

  localparam int ACCW = AW + BW;

  logic                   v_pipe   [BW+1];
  logic signed [AW-1:0]   a_pipe   [BW+1];
  logic signed [BW-1:0]   b_pipe   [BW+1];
  logic signed [ACCW-1:0] acc_pipe [BW+1];

  assign v_pipe[0]   = vin;
  assign a_pipe[0]   = multiplicand;
  assign b_pipe[0]   = multiplier;
  assign acc_pipe[0] = '0;

  for (genvar k = 0; k < BW; k++) begin : g_stage
    mulen_stage #(
      .AW (AW),
      .BW (BW),
      .K  (k)
    ) u_stage (
      .clk     (clk),
      .rst_n   (rst_n),
      .cke     (cke),
      .v_in    (v_pipe[k]),
      .a_in    (a_pipe[k]),
      .b_in    (b_pipe[k]),
      .acc_in  (acc_pipe[k]),
      .v_out   (v_pipe[k+1]),
      .a_out   (a_pipe[k+1]),
      .b_out   (b_pipe[k+1]),
      .acc_out (acc_pipe[k+1])
    );
  end

  rs_t rs;

  always_comb begin
    rs = '0;
    rs = round_sat(wide_t'(acc_pipe[BW]), FRAC, PW);
  end

  // Output stage: product/sat only move when a valid result arrives, so they hold across bubbles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vout    <= 1'b0;
      product <= '0;
      sat     <= 1'b0;
    end else if (cke) begin
      vout <= v_pipe[BW];
      if (v_pipe[BW]) begin
        product <= rs.value[PW-1:0];
        sat     <= rs.sat;
      end
    end
  end

endmodule
